// File: rtl/tx_am_inserter.sv
// 40GBASE-R transmit alignment-marker inserter and 4-lane serdes feeder.
// One AM per lane is inserted every AM_INTERVAL emitted blocks. Each AM
// carries that lane's BIP3, which is the running parity of the blocks since
// the previous AM. Serdes FIFO partial-full stalls the whole stream.
module tx_am_inserter #(
  parameter int unsigned AM_INTERVAL = 16384
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] in_data,
  input  logic [7:0]   in_hdr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   tx_fifo_pfull,
  output logic [255:0] tx_parallel_data,
  output logic [31:0]  tx_control,
  output logic [3:0]   tx_enh_data_valid,
  output logic         am_inserted
);

  localparam int unsigned CntW = $clog2(AM_INTERVAL);
  localparam logic [CntW-1:0] CntMax = CntW'(AM_INTERVAL - 1);

  // Per-lane marker bytes {M2, M1, M0}; M0 goes out first.
  function automatic logic [23:0] am_marker(input int lane);
    logic [23:0] m;
    case (lane)
      0:       m = 24'h477690;
      1:       m = 24'hE6C4F0;
      2:       m = 24'h9B65C5;
      default: m = 24'h3D79A2;
    endcase
    return m;
  endfunction

  // Parity contribution of one 66b block to the BIP accumulator.
  function automatic logic [7:0] bip_contrib(input logic [63:0] d, input logic [1:0] h);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) b ^= d[8*k +: 8];
    b[3] ^= h[0];
    b[4] ^= h[1];
    return b;
  endfunction

  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0][7:0] bip_q, bip_d;
  logic [255:0]    data_q, data_d;
  logic [31:0]     ctrl_q, ctrl_d;
  logic            valid_q, valid_d;
  logic            am_q, am_d;
  logic [63:0]     am_blk [4];

  logic stall, am_slot, emit_am, accept;

  assign stall    = |tx_fifo_pfull;
  assign am_slot  = (cnt_q == '0);
  assign in_ready = !reset && !am_slot && !stall;
  assign emit_am  = !reset && am_slot && !stall;
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;

  // Build the AM for each lane from the parity accumulated so far.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      am_blk[i] = {~bip_q[i], ~am_marker(i), bip_q[i], am_marker(i)};
    end
  end

  // Next-state: pick AM or accepted data; outputs hold when nothing is emitted.
  always_comb begin
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    valid_d = 1'b0;
    am_d    = 1'b0;
    cnt_d   = cnt_q;
    bip_d   = bip_q;
    if (emit_am) begin
      valid_d = 1'b1;
      am_d    = 1'b1;
      cnt_d   = cnt_inc;
      for (int i = 0; i < 4; i++) begin
        data_d[64*i +: 64] = am_blk[i];
        ctrl_d[8*i +: 8]   = 8'h01;
        // Accumulator restarts at the AM's own contribution.
        bip_d[i]           = bip_contrib(am_blk[i], 2'b01);
      end
    end else if (accept) begin
      valid_d = 1'b1;
      cnt_d   = cnt_inc;
      data_d  = in_data;
      for (int i = 0; i < 4; i++) begin
        ctrl_d[8*i +: 8] = {6'b0, in_hdr[2*i +: 2]};
        bip_d[i]         = bip_q[i] ^ bip_contrib(in_data[64*i +: 64], in_hdr[2*i +: 2]);
      end
    end
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      bip_q   <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      am_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bip_q   <= bip_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      am_q    <= am_d;
    end
  end

  assign tx_parallel_data  = data_q;
  assign tx_control        = ctrl_q;
  assign tx_enh_data_valid = {4{valid_q}};
  assign am_inserted       = am_q;

endmodule

// File: tb/tb_tx_am_inserter.sv
// Directed bench for tx_am_inserter with AM_INTERVAL=4. A reference model
// pushes expected emissions into a scoreboard queue as stimulus is driven;
// entries are popped when the DUT raises its valid output.
module tb_tx_am_inserter;

  localparam int unsigned AmInterval = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] in_data;
  logic [7:0]   in_hdr;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   tx_fifo_pfull;
  logic [255:0] tx_parallel_data;
  logic [31:0]  tx_control;
  logic [3:0]   tx_enh_data_valid;
  logic         am_inserted;

  always #5 clk = ~clk;

  tx_am_inserter #(.AM_INTERVAL(AmInterval)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_data          (in_data),
    .in_hdr           (in_hdr),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .tx_fifo_pfull    (tx_fifo_pfull),
    .tx_parallel_data (tx_parallel_data),
    .tx_control       (tx_control),
    .tx_enh_data_valid(tx_enh_data_valid),
    .am_inserted      (am_inserted)
  );

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  ctrl;
    logic         am;
  } exp_t;

  exp_t         sb[$];
  int           ncmp = 0;
  int           nfail = 0;
  int           m_cnt;
  logic [7:0]   m_bip [4];
  logic [255:0] last_data;
  logic [31:0]  last_ctrl;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Marker bytes in transmit order M0, M1, M2.
  function automatic logic [7:0] mbyte(input int lane, input int k);
    logic [23:0] t;
    case (lane)
      0:       t = {8'h90, 8'h76, 8'h47};
      1:       t = {8'hF0, 8'hC4, 8'hE6};
      2:       t = {8'hC5, 8'h65, 8'h9B};
      default: t = {8'hA2, 8'h79, 8'h3D};
    endcase
    return t[23 - 8*k -: 8];
  endfunction

  function automatic logic [63:0] ref_am(input int lane, input logic [7:0] bip);
    logic [63:0] r;
    for (int k = 0; k < 3; k++) begin
      r[8*k +: 8]       = mbyte(lane, k);
      r[8*(k+4) +: 8]   = ~mbyte(lane, k);
    end
    r[31:24] = bip;
    r[63:56] = ~bip;
    return r;
  endfunction

  function automatic logic [7:0] ref_par(input logic [63:0] d, input logic [1:0] h);
    logic [7:0] p;
    p = d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24] ^ d[39:32] ^ d[47:40] ^ d[55:48] ^ d[63:56];
    return p ^ {3'b0, h[1], h[0], 3'b0};
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int i = 0; i < 4; i++) m_bip[i] = 8'h00;
    sb.delete();
    last_data = '0;
    last_ctrl = '0;
  endtask

  // Hold reset for n cycles and check that everything is cleared.
  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int c = 0; c < n; c++) begin
      #1;
      chk("rst_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      chk("rst_data", tx_parallel_data, '0);
      chk("rst_ctrl", tx_control, '0);
      chk("rst_valid", tx_enh_data_valid, '0);
      chk("rst_am", am_inserted, 1'b0);
    end
    reset = 1'b0;
    model_reset();
  endtask

  // One cycle: drive inputs, predict, clock, compare.
  task automatic step(input logic v, input logic [255:0] d, input logic [7:0] h,
                      input logic [3:0] pf);
    exp_t e;
    logic stall, rdy, do_am, do_acc;
    exp_t got;
    in_valid = v;
    in_data = d;
    in_hdr = h;
    tx_fifo_pfull = pf;
    #1;
    stall  = |pf;
    rdy    = (m_cnt != 0) && !stall;
    do_am  = (m_cnt == 0) && !stall;
    do_acc = v && rdy;
    chk("in_ready", in_ready, rdy);
    e = '0;
    if (do_am) begin
      e.am = 1'b1;
      for (int i = 0; i < 4; i++) begin
        e.data[64*i +: 64] = ref_am(i, m_bip[i]);
        e.ctrl[8*i +: 8]   = 8'h01;
        m_bip[i]           = ref_par(e.data[64*i +: 64], 2'b01);
      end
    end else if (do_acc) begin
      e.data = d;
      for (int i = 0; i < 4; i++) begin
        e.ctrl[8*i +: 8] = {6'b0, h[2*i +: 2]};
        m_bip[i]         = m_bip[i] ^ ref_par(d[64*i +: 64], h[2*i +: 2]);
      end
    end
    if (do_am || do_acc) begin
      sb.push_back(e);
      m_cnt = (m_cnt + 1) % AmInterval;
    end
    @(posedge clk);
    #1;
    chk("out_valid", tx_enh_data_valid, {4{do_am | do_acc}});
    chk("am_pulse", am_inserted, do_am);
    if (tx_enh_data_valid[0] === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1'b1, 1'b0);
      end else begin
        got = sb.pop_front();
        chk("out_data", tx_parallel_data, got.data);
        chk("out_ctrl", tx_control, got.ctrl);
        chk("out_am", am_inserted, got.am);
        last_data = got.data;
        last_ctrl = got.ctrl;
      end
    end else begin
      chk("hold_data", tx_parallel_data, last_data);
      chk("hold_ctrl", tx_control, last_ctrl);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_hdr = '0;
    tx_fifo_pfull = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(2);

    // First AM after reset, BIP3 = 00.
    step(1'b1, '0, 8'hAA, 4'h0);
    chk("am1_lane0", tx_parallel_data[63:0], 64'hFFB8896F00477690);
    chk("am1_lane1", tx_parallel_data[127:64], 64'hFF193B0F00E6C4F0);
    chk("am1_hdr0", tx_control[7:0], 8'h01);

    // Three all-zero data blocks, then AM with BIP3 = 18 on every lane.
    for (int k = 0; k < 3; k++) step(1'b1, '0, 8'hAA, 4'h0);
    step(1'b1, '0, 8'hAA, 4'h0);
    chk("am2_lane0", tx_parallel_data[63:0], 64'hE7B8896F18477690);
    for (int i = 1; i < 4; i++) begin
      chk("am2_bip3", tx_parallel_data[64*i+24 +: 8], 8'h18);
      chk("am2_bip7", tx_parallel_data[64*i+56 +: 8], 8'hE7);
    end

    // Lane 2 pfull for two cycles mid-period.
    step(1'b1, rnd256(), 8'h69, 4'h0);
    step(1'b1, rnd256(), 8'h96, 4'h4);
    step(1'b1, rnd256(), 8'h96, 4'h4);
    step(1'b1, rnd256(), 8'h5A, 4'h0);
    step(1'b1, rnd256(), 8'hA5, 4'h0);
    step(1'b1, rnd256(), 8'hAA, 4'h0);
    chk("am_after_stall", am_inserted, 1'b1);

    // in_valid toggling 1,0,1,0,1 then AM.
    step(1'b1, rnd256(), 8'hAA, 4'h0);
    step(1'b0, rnd256(), 8'h55, 4'h0);
    step(1'b1, rnd256(), 8'h55, 4'h0);
    step(1'b0, rnd256(), 8'hAA, 4'h0);
    step(1'b1, rnd256(), 8'h66, 4'h0);
    step(1'b0, rnd256(), 8'hAA, 4'h0);
    chk("am_after_toggle", am_inserted, 1'b1);

    // Reach the AM slot, then hold lane 0 pfull for three cycles.
    for (int k = 0; k < 3; k++) step(1'b1, rnd256(), 8'hAA, 4'h0);
    for (int k = 0; k < 3; k++) step(1'b1, rnd256(), 8'hAA, 4'h1);
    step(1'b1, rnd256(), 8'hAA, 4'h0);
    chk("am_after_pfull", am_inserted, 1'b1);

    // Reset after two data blocks; first emission afterwards is a clean AM.
    step(1'b1, rnd256(), 8'hAA, 4'h0);
    step(1'b1, rnd256(), 8'h55, 4'h0);
    do_reset(1);
    step(1'b1, rnd256(), 8'hAA, 4'h0);
    chk("post_rst_am_lane0", tx_parallel_data[63:0], 64'hFFB8896F00477690);
    for (int k = 0; k < 5; k++) step(1'b1, rnd256(), 8'hAA, 4'h0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/tx_am_inserter.md
# tx_am_inserter

Transmit-side 40GBASE-R alignment-marker (AM) inserter and lane feeder for the 4-lane `pma_40gbe_serdes` enhanced-PCS TX path. It accepts one 66b block per lane per cycle, already scrambled and lane-distributed, and inserts a per-lane AM with BIP3/BIP7 once every `AM_INTERVAL` blocks. It drives `tx_parallel_data`, `tx_control` and `tx_enh_data_valid`, and honours `tx_fifo_pfull` backpressure. It is the TX counterpart of the RX lane-data extraction in `eth_40gb` and sits between the PCS encoder/scrambler and the serdes in the `core_clk` domain.

## Interface
- `AM_INTERVAL`, default 16384: blocks per lane per AM period, AM included; must be ≥2.
- `clk` in 1: `core_clk`.
- `reset` in 1: synchronous, active-high.
- `in_data` in 256: lane i payload is `in_data[64i+:64]`, bit 0 transmitted first.
- `in_hdr` in 8: lane i sync header is `in_hdr[2i+:2]`, bit 0 transmitted first. Data = 2'b10, control = 2'b01.
- `in_valid` in 1: all four lane blocks are valid.
- `in_ready` out 1: block accepted when `in_valid & in_ready`.
- `tx_fifo_pfull` in 4: serdes TX FIFO partial-full, per lane.
- `tx_parallel_data` out 256: lane i is `[64i+:64]`.
- `tx_control` out 32: lane i `[8i+:2]` = header, `[8i+2+:6]` = 0.
- `tx_enh_data_valid` out 4: all bits equal `out_valid`.
- `am_inserted` out 1: one-cycle pulse, coincident with AM on the outputs.

## Operation
- `stall = |tx_fifo_pfull`.
- Period counter `cnt` runs 0..`AM_INTERVAL`-1, reset 0.
- **AM slot** (`cnt==0`):
  - `in_ready` = 0.
  - If `!stall`, emit AM on all lanes and advance `cnt`.
- **Data slot** (`cnt!=0`):
  - `in_ready = !stall`.
  - On accept, register the input blocks to the outputs unchanged and advance `cnt`.
- `cnt` advances only on emission and wraps from `AM_INTERVAL`-1 to 0.
- AM for lane i:
  - Header is 2'b01.
  - Payload bytes B0..B7 are M0, M1, M2, BIP3, ~M0, ~M1, ~M2, ~BIP3, where B0 = bits [7:0].
  - Lane 0 M0..M2 = 90 76 47; lane 1 = F0 C4 E6; lane 2 = C5 65 9B; lane 3 = A2 79 3D.
- BIP, per lane, 8-bit accumulator `bip[i]`, reset 0:
  - Per-block contribution = XOR of payload bytes B0..B7; then bit 3 ^= hdr[0] and bit 4 ^= hdr[1].
  - Every emitted block, data or AM, is XORed into `bip[i]`.
  - An AM carries BIP3 = the accumulator value before that AM.
  - Once the AM is emitted, the accumulator restarts at that AM's own contribution, which is always 0x08.
  - The first AM after reset carries BIP3 = 0x00.
- No emission this cycle: `out_valid` = 0, `am_inserted` = 0, `tx_parallel_data`/`tx_control` hold, state holds.
- Reset (any cycle, including mid-period):
  - All outputs are 0.
  - `cnt` = 0 and `bip` = 0.
  - Pending data is discarded.
  - The first emission after reset is an AM.

## Timing
- Combinational `in_ready`; it is 0 while `reset` is high.
- Latency: exactly 1 cycle from accept or AM decision to the outputs.
- At full rate with no stall, each period is 1 AM cycle followed by `AM_INTERVAL`-1 data cycles.
- Stall asserted in the AM slot: the AM is delayed; no data is accepted until the AM is emitted.
- Stall and `in_valid` in the same cycle: not accepted; the upstream block must be held.
- `in_valid` low in a data slot: no emission; the period is measured in emitted blocks, not cycles.

## Test plan
All scenarios use `AM_INTERVAL=4`.
- **Reset release, `in_valid`=1 constant:**
  - Cycle 0: `in_ready`=0.
  - Next cycle, lane 0 output = 90 76 47 00 6F 89 B8 FF, hdr 01; lanes 1–3 carry their markers; `am_inserted`=1.
  - Then 3 data cycles, then an AM, repeating.
- **BIP check:** after the first AM, send 3 all-zero payload blocks with hdr 10.
  - Second AM lane 0 = 90 76 47 18 6F 89 B8 E7.
  - Same BIP3 = 0x18 on every lane.
- **`tx_fifo_pfull[2]`=1 for 2 cycles mid-period:**
  - `in_ready`=0 and `tx_enh_data_valid`=0 for those cycles.
  - The next AM still follows exactly 3 data blocks.
- **`in_valid` toggling 1,0,1,0:**
  - Data is emitted 1 cycle after each accept.
  - The AM appears after the 3rd accepted block; the stream is intact.
- **`tx_fifo_pfull[0]` high on the AM slot for 3 cycles:**
  - No AM and `in_ready`=0 throughout.
  - The AM is emitted 1 cycle after pfull drops.
- **`reset` pulsed after 2 data blocks:**
  - Outputs go to 0.
  - The first post-reset emission is an AM with BIP3 = 00 and BIP7 = FF.
